// File: rtl/instr_encoder.sv
// LEGv8-style instruction encoder: turns one command per cycle into a 32-bit
// instruction word behind a valid/ready output stage with address and count tracking.
`timescale 1ns/1ps

module instr_encoder (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_op,
    input  logic [4:0]  cmd_rd,
    input  logic [4:0]  cmd_rn,
    input  logic [4:0]  cmd_rm,
    input  logic [25:0] cmd_imm,
    input  logic [1:0]  cmd_hw,
    input  logic        restart,
    input  logic [63:0] start_addr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [63:0] out_addr,
    output logic [15:0] instr_count,
    output logic        err_illegal
);

    typedef enum logic [3:0] {
        OP_AND  = 4'd0,
        OP_ORR  = 4'd1,
        OP_ADD  = 4'd2,
        OP_SUB  = 4'd3,
        OP_ADDI = 4'd4,
        OP_SUBI = 4'd5,
        OP_MOVZ = 4'd6,
        OP_B    = 4'd7,
        OP_CBZ  = 4'd8,
        OP_LDUR = 4'd9,
        OP_STUR = 4'd10
    } op_e;

    logic [31:0] enc_word;
    logic        enc_legal;
    logic        out_fire;
    logic        cmd_fire;

    assign cmd_ready = !out_valid || out_ready;
    assign out_fire  = out_valid && out_ready;
    // A restart cycle never accepts a command, even though cmd_ready may be high.
    assign cmd_fire  = cmd_valid && cmd_ready && !restart;

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        enc_word  = '0;
        enc_legal = 1'b1;
        case (op_e'(cmd_op))
            OP_AND:  enc_word = {11'b10001010000, cmd_rm, 6'b000000, cmd_rn, cmd_rd};
            OP_ORR:  enc_word = {11'b10101010000, cmd_rm, 6'b000000, cmd_rn, cmd_rd};
            OP_ADD:  enc_word = {11'b10001011000, cmd_rm, 6'b000000, cmd_rn, cmd_rd};
            OP_SUB:  enc_word = {11'b11001011000, cmd_rm, 6'b000000, cmd_rn, cmd_rd};
            OP_ADDI: enc_word = {10'b1001000100, cmd_imm[11:0], cmd_rn, cmd_rd};
            OP_SUBI: enc_word = {10'b1101000100, cmd_imm[11:0], cmd_rn, cmd_rd};
            OP_MOVZ: enc_word = {9'b110100101, cmd_hw, cmd_imm[15:0], cmd_rd};
            OP_B:    enc_word = {6'b000101, cmd_imm};
            OP_CBZ:  enc_word = {8'b10110100, cmd_imm[18:0], cmd_rd};
            OP_LDUR: enc_word = {11'b11111000010, cmd_imm[8:0], 2'b00, cmd_rn, cmd_rd};
            OP_STUR: enc_word = {11'b11111000000, cmd_imm[8:0], 2'b00, cmd_rn, cmd_rd};
            default: enc_legal = 1'b0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            out_valid   <= 1'b0;
            out_instr   <= '0;
            out_addr    <= '0;
            instr_count <= '0;
            err_illegal <= 1'b0;
        end else if (restart) begin
            out_valid   <= 1'b0;
            out_addr    <= start_addr;
            instr_count <= '0;
            err_illegal <= 1'b0;
        end else begin
            // out_addr names the word on the output, so it moves only when a word leaves.
            if (out_fire) begin
                out_valid   <= 1'b0;
                out_addr    <= out_addr + 64'd4;
                instr_count <= instr_count + 16'd1;
            end
            if (cmd_fire) begin
                if (enc_legal) begin
                    out_instr <= enc_word;
                    out_valid <= 1'b1;
                end else begin
                    err_illegal <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: directed reference vectors, stall, illegal,
// restart and reset cases, then randomized traffic against a field-table model.
`timescale 1ns/1ps

module tb_instr_encoder;

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_op = '0;
    logic [4:0]  cmd_rd = '0;
    logic [4:0]  cmd_rn = '0;
    logic [4:0]  cmd_rm = '0;
    logic [25:0] cmd_imm = '0;
    logic [1:0]  cmd_hw = '0;
    logic        restart = 1'b0;
    logic [63:0] start_addr = '0;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [63:0] out_addr;
    logic [15:0] instr_count;
    logic        err_illegal;

    logic        rand_mode = 1'b0;
    logic        dir_ready = 1'b0;
    logic        rnd_ready = 1'b1;
    logic        out_ready_w;
    assign out_ready_w = rand_mode ? rnd_ready : dir_ready;

    instr_encoder dut (
        .CLK         (CLK),
        .Reset       (Reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_rd      (cmd_rd),
        .cmd_rn      (cmd_rn),
        .cmd_rm      (cmd_rm),
        .cmd_imm     (cmd_imm),
        .cmd_hw      (cmd_hw),
        .restart     (restart),
        .start_addr  (start_addr),
        .out_valid   (out_valid),
        .out_ready   (out_ready_w),
        .out_instr   (out_instr),
        .out_addr    (out_addr),
        .instr_count (instr_count),
        .err_illegal (err_illegal)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [31:0] instr;
        logic [63:0] addr;
        logic [15:0] cnt;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          passed = 0;
    int          total = 0;
    logic [63:0] model_addr = '0;
    logic [15:0] model_cnt = '0;
    logic        model_err = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    endtask

    // Reference encoder built from the format table: opcode value placed at its
    // field position, operands masked to their field width and shifted into place.
    function automatic logic [31:0] model_enc(input logic [3:0] op, input logic [4:0] rd,
                                              input logic [4:0] rn, input logic [4:0] rm,
                                              input logic [25:0] imm, input logic [1:0] hw);
        logic [31:0] r, n, m, i, h;
        r = {27'b0, rd};
        n = {27'b0, rn};
        m = {27'b0, rm};
        i = {6'b0, imm};
        h = {30'b0, hw};
        case (op)
            4'd0:  return (32'h450 << 21) | (m << 16) | (n << 5) | r;
            4'd1:  return (32'h550 << 21) | (m << 16) | (n << 5) | r;
            4'd2:  return (32'h458 << 21) | (m << 16) | (n << 5) | r;
            4'd3:  return (32'h658 << 21) | (m << 16) | (n << 5) | r;
            4'd4:  return (32'h244 << 22) | ((i & 32'hFFF) << 10) | (n << 5) | r;
            4'd5:  return (32'h344 << 22) | ((i & 32'hFFF) << 10) | (n << 5) | r;
            4'd6:  return (32'h1A5 << 23) | (h << 21) | ((i & 32'hFFFF) << 5) | r;
            4'd7:  return (32'h5 << 26) | i;
            4'd8:  return (32'hB4 << 24) | ((i & 32'h7FFFF) << 5) | r;
            4'd9:  return (32'h7C2 << 21) | ((i & 32'h1FF) << 12) | (n << 5) | r;
            4'd10: return (32'h7C0 << 21) | ((i & 32'h1FF) << 12) | (n << 5) | r;
            default: return 32'h0;
        endcase
    endfunction

    // Called and returns at 1 ns after a rising edge.
    task automatic issue(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rn,
                         input logic [4:0] rm, input logic [25:0] imm, input logic [1:0] hw,
                         input bit use_lit, input logic [31:0] lit, output int waits);
        bit   got;
        exp_t x;
        got = 1'b0;
        waits = 0;
        cmd_valid = 1'b1;
        cmd_op = op; cmd_rd = rd; cmd_rn = rn; cmd_rm = rm; cmd_imm = imm; cmd_hw = hw;
        while (!got && waits < 200) begin
            @(negedge CLK);
            waits++;
            if (cmd_ready) got = 1'b1;
        end
        if (!got) begin
            total++;
            $display("FAIL cmd_accept_timeout: cmd_ready low for %0d cycles, required 1", waits);
        end else if (op <= 4'd10) begin
            x.instr = use_lit ? lit : model_enc(op, rd, rn, rm, imm, hw);
            x.addr  = model_addr;
            x.cnt   = model_cnt;
            sb.push_back(x);
            model_addr += 64'd4;
            model_cnt  += 16'd1;
        end else begin
            model_err = 1'b1;
        end
        @(posedge CLK);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic issue_rand();
        int w;
        logic [3:0] op;
        op = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(11, 15)) : 4'($urandom_range(0, 10));
        issue(op, 5'($urandom), 5'($urandom), 5'($urandom), 26'($urandom), 2'($urandom), 1'b0, '0, w);
    endtask

    task automatic do_restart(input logic [63:0] a);
        restart = 1'b1;
        start_addr = a;
        @(posedge CLK);
        #1;
        restart = 1'b0;
        sb.delete();
        model_addr = a;
        model_cnt = '0;
        model_err = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge CLK);
            n++;
        end
        if (sb.size() != 0) begin
            total++;
            $display("FAIL drain_timeout: %0d words still expected, required 0", sb.size());
        end
        @(posedge CLK);
        #1;
    endtask

    // Monitor: every completed output handshake is compared against the queue head.
    initial begin
        forever begin
            @(negedge CLK);
            if (!Reset && !restart && out_valid && out_ready_w) begin
                if (sb.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_word: got instr 0x%0h addr 0x%0h, required no word",
                             out_instr, out_addr);
                end else begin
                    mon_e = sb.pop_front();
                    check("word_instr", 64'(out_instr), 64'(mon_e.instr));
                    check("word_addr", out_addr, mon_e.addr);
                    check("word_count", 64'(instr_count), 64'(mon_e.cnt));
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge CLK);
            #1;
            rnd_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        logic [15:0] cnt_before;

        repeat (2) @(posedge CLK);
        #1;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out_instr", 64'(out_instr), 64'd0);
        check("reset_out_addr", out_addr, 64'd0);
        check("reset_count", 64'(instr_count), 64'd0);
        check("reset_err", 64'(err_illegal), 64'd0);
        Reset = 1'b0;
        @(posedge CLK);
        #1;
        check("ready_after_reset", 64'(cmd_ready), 64'd1);

        // Reference vectors with literal expected words
        dir_ready = 1'b1;
        issue(4'd2, 5'd3, 5'd1, 5'd2, 26'd0, 2'd0, 1'b1, 32'h8B020023, w);
        drain();
        check("count_after_add", 64'(instr_count), 64'd1);
        issue(4'd4, 5'd2, 5'd0, 5'd0, 26'd5, 2'd0, 1'b1, 32'h91001402, w);
        issue(4'd6, 5'd9, 5'd0, 5'd0, 26'h1234, 2'd1, 1'b1, 32'hD2A24689, w);
        issue(4'd7, 5'd0, 5'd0, 5'd0, 26'h3FFFFFF, 2'd0, 1'b1, 32'h17FFFFFF, w);
        issue(4'd8, 5'd1, 5'd0, 5'd0, 26'd2, 2'd0, 1'b1, 32'hB4000041, w);
        issue(4'd9, 5'd10, 5'd2, 5'd0, 26'd8, 2'd0, 1'b1, 32'hF840804A, w);
        drain();

        // Output stall: word held, cmd_ready low, then back-to-back at 0x0, 0x4, 0x8
        do_restart(64'd0);
        dir_ready = 1'b0;
        issue(4'd2, 5'd3, 5'd1, 5'd2, 26'd0, 2'd0, 1'b1, 32'h8B020023, w);
        fork
            issue(4'd1, 5'd7, 5'd8, 5'd9, 26'd0, 2'd0, 1'b0, '0, w);
            begin
                repeat (3) begin
                    @(negedge CLK);
                    check("stall_cmd_ready", 64'(cmd_ready), 64'd0);
                    check("stall_valid", 64'(out_valid), 64'd1);
                    check("stall_instr", 64'(out_instr), 64'h8B020023);
                    check("stall_addr", out_addr, 64'd0);
                end
                @(posedge CLK);
                #1;
                dir_ready = 1'b1;
            end
        join
        issue(4'd10, 5'd4, 5'd5, 5'd0, 26'h1FF, 2'd0, 1'b0, '0, w);
        check("back_to_back_accept", 64'(w), 64'd1);
        drain();

        // Illegal op then restart
        check("err_clear_before_illegal", 64'(err_illegal), 64'd0);
        cnt_before = instr_count;
        issue(4'd13, 5'd1, 5'd1, 5'd1, 26'd1, 2'd0, 1'b0, '0, w);
        @(negedge CLK);
        check("illegal_no_valid", 64'(out_valid), 64'd0);
        check("illegal_err", 64'(err_illegal), 64'd1);
        check("illegal_count", 64'(instr_count), 64'(model_cnt));
        check("illegal_addr", out_addr, model_addr);
        @(posedge CLK);
        #1;
        do_restart(64'h400);
        check("restart_err", 64'(err_illegal), 64'd0);
        check("restart_addr", out_addr, 64'h400);
        check("restart_count", 64'(instr_count), 64'd0);
        issue(4'd3, 5'd5, 5'd6, 5'd7, 26'd0, 2'd0, 1'b0, '0, w);
        drain();
        check("count_nonzero_before_illegal", 64'(cnt_before != 16'd0), 64'd1);

        // Random traffic across the 2^64 address wrap
        do_restart(64'hFFFF_FFFF_FFFF_FFF8);
        rand_mode = 1'b1;
        for (int i = 0; i < 400; i++) begin
            issue_rand();
            if ($urandom_range(0, 3) == 0) begin
                @(posedge CLK);
                #1;
            end
        end
        rand_mode = 1'b0;
        dir_ready = 1'b1;
        drain();
        check("random_err_flag", 64'(err_illegal), 64'(model_err));
        check("random_final_addr", out_addr, model_addr);
        check("random_final_count", 64'(instr_count), 64'(model_cnt));

        // Asynchronous reset in the middle of a stall
        dir_ready = 1'b0;
        issue(4'd0, 5'd1, 5'd2, 5'd3, 26'd0, 2'd0, 1'b0, '0, w);
        @(posedge CLK);
        #2;
        Reset = 1'b1;
        #1;
        check("midstall_reset_valid", 64'(out_valid), 64'd0);
        check("midstall_reset_count", 64'(instr_count), 64'd0);
        check("midstall_reset_addr", out_addr, 64'd0);
        sb.delete();
        model_addr = '0;
        model_cnt = '0;
        model_err = 1'b0;
        @(negedge CLK);
        Reset = 1'b0;
        @(posedge CLK);
        #1;
        check("ready_after_midstall_reset", 64'(cmd_ready), 64'd1);
        dir_ready = 1'b1;
        issue(4'd5, 5'd11, 5'd12, 5'd0, 26'hABC, 2'd0, 1'b0, '0, w);
        drain();
        check("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
